laser_rx_deframer: RTL and testbench
====================================

LASER_RX_DEFRAMER -- requirements
Module: laser_rx_deframer

Interface
REQ-001 Parameter OVERSAMPLE, default 8, clock cycles per laser bit period; the block SHALL support only even values >= 4.
REQ-002 Parameter SKEW_MAX, default 16, maximum clock cycles allowed between lane-1 and lane-2 byte completion.
REQ-003 clock  input  1  sole clock; all state SHALL be on its rising edge (CLOCK_50 at top level).
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 laser1_in  input  1  lane-1 photodiode line; asynchronous to clock.
REQ-006 laser2_in  input  1  lane-2 photodiode line; asynchronous to clock.
REQ-007 data1_in  output  8  last accepted lane-1 byte.
REQ-008 data2_in  output  8  last accepted lane-2 byte.
REQ-009 data_valid  output  1  one-cycle pulse when a new byte pair is present on data1_in and data2_in.
REQ-010 frame_error  output  1  one-cycle pulse on a bad stop bit on either lane.
REQ-011 skew_error  output  1  one-cycle pulse on a lane-pair timeout.

Function
REQ-012 Frame per lane: idle 0 (laser off), start bit 1, 8 data bits LSB first, stop bit 0, each bit OVERSAMPLE cycles long.
REQ-013 Each laser input SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Each lane SHALL run an independent FSM with states IDLE, START, DATA, STOP and a bit-period counter.
REQ-015 IDLE -> START on the first cycle the synchronized input is 1; the counter clears to 0.
REQ-016 In START, the input SHALL be sampled at counter = OVERSAMPLE/2-1: 1 -> DATA with the counter cleared; 0 -> IDLE (glitch rejected, no flag).
REQ-017 In DATA, one bit SHALL be sampled every OVERSAMPLE cycles, aligned to mid-bit, and shifted into the lane byte LSB first; after the 8th bit -> STOP.
REQ-018 In STOP, the input SHALL be sampled at mid-bit: 0 -> lane byte accepted and pending, then IDLE; 1 -> frame_error pulses the next cycle, the byte is discarded, and the FSM waits in STOP until the input reads 0, then IDLE.
REQ-019 Pairing: when both lanes have a pending byte, data1_in/data2_in SHALL update and data_valid SHALL pulse on the next cycle, and both pendings clear.
REQ-020 Simultaneous acceptance on both lanes SHALL produce data_valid exactly one cycle after the shared stop-sample cycle.
REQ-021 If one lane is pending for SKEW_MAX cycles without its partner, that pending byte SHALL be discarded and skew_error pulses for one cycle; data1_in/data2_in hold.
REQ-022 A lane accepting a second byte while still pending SHALL overwrite its pending byte and restart its skew timer.
REQ-023 data1_in/data2_in SHALL change only on data_valid cycles.
REQ-024 frame_error and skew_error in the same cycle SHALL both assert.

Reset
REQ-025 While reset_n = 0: FSMs SHALL be IDLE, counters, synchronizers, pending flags and skew timers 0, data1_in = data2_in = 8'h00, and data_valid, frame_error, skew_error = 0.
REQ-026 Reset asserted mid-frame SHALL abort both lanes with no output pulse; after release, reception SHALL resume on the next start bit.

Configuration
REQ-027 Macro LASER_RX_MAJORITY_EN defined: each START/DATA/STOP sample SHALL be the 2-of-3 majority of the synchronized input at cycles mid-1, mid and mid+1, with the decision taken at mid+1; all latencies grow by 1 cycle.
REQ-028 Macro LASER_RX_MAJORITY_EN undefined: single sample at mid-bit, per REQ-016 to REQ-018.

Verification (OVERSAMPLE=8, SKEW_MAX=16)
REQ-029 Both lanes are sent 0x12 and 0x34 aligned -> one data_valid pulse, data1_in=0x12, data2_in=0x34, no errors.
REQ-030 A 2-cycle high glitch is applied on lane 1 -> FSM returns to IDLE, no flags, and a following 0xC8/0x77 pair is received correctly.
REQ-031 Lane 2 frame has stop bit 1 -> frame_error pulse, no data_valid, outputs hold the prior values.
REQ-032 Lane 2 is delayed 5 cycles relative to lane 1 with 0xA5/0x5A -> data_valid fires after lane 2 is accepted with the correct bytes; lane 2 silent -> skew_error 16 cycles after lane-1 acceptance.
REQ-033 reset_n is pulsed low during lane-1 data bit 4 -> outputs are 0, no pulses, and the next aligned 0xFF/0x00 frame is received.
REQ-034 With LASER_RX_MAJORITY_EN defined, a 1-cycle inversion is forced at each mid-bit of 0x3C/0xC3 -> bytes are received correctly.

Source files
------------

// File: rtl/laser_rx_deframer_if.sv
// laser_rx_deframer_if: laser lane inputs and deframed byte-pair outputs.
// The deframer uses the slave view; the optical source / consumer side uses master.
interface laser_rx_deframer_if;
  logic       laser1_in;
  logic       laser2_in;
  logic [7:0] data1_in;
  logic [7:0] data2_in;
  logic       data_valid;
  logic       frame_error;
  logic       skew_error;

  modport master (
    output laser1_in, laser2_in,
    input  data1_in, data2_in, data_valid, frame_error, skew_error
  );

  modport slave (
    input  laser1_in, laser2_in,
    output data1_in, data2_in, data_valid, frame_error, skew_error
  );
endinterface

// File: rtl/laser_rx_deframer.sv
// laser_rx_deframer: two-lane oversampled laser-link receiver. Each lane is a
// 2-flop synchronizer followed by an IDLE/START/DATA/STOP framer (start 1,
// 8 data bits LSB first, stop 0). Accepted bytes wait as "pending" until the
// partner lane delivers; a pending byte older than SKEW_MAX cycles is dropped.
// Optional feature: define LASER_RX_MAJORITY_EN for a 2-of-3 vote across
// mid-1/mid/mid+1, which shifts every decision one cycle later.
module laser_rx_deframer #(
  parameter int OVERSAMPLE = 8,  // even, >= 4
  parameter int SKEW_MAX   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  laser_rx_deframer_if.slave rx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int TW = $clog2(SKEW_MAX + 1);
`ifdef LASER_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam logic [CW-1:0] START_LAST = CW'(OVERSAMPLE / 2 - 1 + MAJ);
  localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SKEW_LAST  = TW'(SKEW_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]          laser;
  logic [1:0]          meta_q, sync_q;
  logic [1:0]          sample;
  logic [1:0][1:0]     st_q, st_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [1:0][2:0]     bit_q, bit_d;
  logic [1:0][7:0]     shr_q, shr_d;
  logic [1:0]          werr_q, werr_d;
  logic [1:0]          acc, ferr;
  logic [1:0]          pend_q, pend_d;
  logic [1:0]          eff;
  logic [1:0][7:0]     pbyte_q, pbyte_d;
  logic [1:0][TW-1:0]  tmr_q, tmr_d;
  logic [7:0]          data1_q, data1_d, data2_q, data2_d;
  logic                dv_q, dv_d, fe_q, fe_d, se_q, se_d;

  assign laser = {rx.laser2_in, rx.laser1_in};

`ifdef LASER_RX_MAJORITY_EN
  logic [1:0] hist0_q, hist1_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchronize both lanes and keep two cycles of history for the vote
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= '0;
      sync_q  <= '0;
      hist0_q <= '0;
      hist1_q <= '0;
    end else begin
      meta_q  <= laser;
      sync_q  <= meta_q;
      hist0_q <= sync_q;
      hist1_q <= hist0_q;
    end
  end

  // Vote over mid-1 (hist1), mid (hist0) and mid+1 (current)
  always_comb begin
    sample = '0;
    for (int i = 0; i < 2; i++) sample[i] = maj3(hist1_q[i], hist0_q[i], sync_q[i]);
  end
`else
  // Synchronize both lanes before any use
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= laser;
      sync_q <= meta_q;
    end
  end

  assign sample = sync_q;
`endif

  // Per-lane framer: bit-period counter runs freely and restarts at each decision
  always_comb begin
    st_d   = st_q;
    bit_d  = bit_q;
    shr_d  = shr_q;
    werr_d = werr_q;
    cnt_d  = cnt_q;
    acc    = '0;
    ferr   = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(1);
      case (st_q[i])
        S_IDLE: begin
          cnt_d[i] = '0;
          if (sync_q[i]) st_d[i] = S_START;
        end
        S_START: begin
          if (cnt_q[i] == START_LAST) begin
            cnt_d[i] = '0;
            bit_d[i] = 3'd0;
            st_d[i]  = sample[i] ? S_DATA : S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_q[i] == BIT_LAST) begin
            cnt_d[i] = '0;
            shr_d[i] = {sample[i], shr_q[i][7:1]};
            bit_d[i] = bit_q[i] + 3'd1;
            if (bit_q[i] == 3'd7) st_d[i] = S_STOP;
          end
        end
        default: begin
          // S_STOP; werr marks a bad stop bit still being held high
          if (werr_q[i]) begin
            cnt_d[i] = '0;
            if (!sync_q[i]) begin
              st_d[i]   = S_IDLE;
              werr_d[i] = 1'b0;
            end
          end else if (cnt_q[i] == BIT_LAST) begin
            cnt_d[i] = '0;
            if (sample[i]) begin
              ferr[i]   = 1'b1;
              werr_d[i] = 1'b1;
            end else begin
              acc[i]  = 1'b1;
              st_d[i] = S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Pairing: an acceptance this cycle counts as pending, so simultaneous
  // stop samples pair with one cycle of latency. Timer = cycles since acceptance.
  always_comb begin
    pend_d  = pend_q;
    pbyte_d = pbyte_q;
    tmr_d   = tmr_q;
    data1_d = data1_q;
    data2_d = data2_q;
    dv_d    = 1'b0;
    se_d    = 1'b0;
    fe_d    = |ferr;
    eff     = pend_q | acc;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        pend_d[i]  = 1'b1;
        pbyte_d[i] = shr_q[i];
        tmr_d[i]   = TW'(1);
      end else if (pend_q[i]) begin
        tmr_d[i] = tmr_q[i] + TW'(1);
      end
    end
    if (&eff) begin
      dv_d    = 1'b1;
      data1_d = acc[0] ? shr_q[0] : pbyte_q[0];
      data2_d = acc[1] ? shr_q[1] : pbyte_q[1];
      pend_d  = '0;
      tmr_d   = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pend_q[i] && !acc[i] && tmr_q[i] == SKEW_LAST) begin
          pend_d[i] = 1'b0;
          tmr_d[i]  = '0;
          se_d      = 1'b1;
        end
      end
    end
  end

  // Framer state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= {S_IDLE, S_IDLE};
      cnt_q  <= '0;
      bit_q  <= '0;
      shr_q  <= '0;
      werr_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      shr_q  <= shr_d;
      werr_q <= werr_d;
    end
  end

  // Pairing state and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= '0;
      pbyte_q <= '0;
      tmr_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pbyte_q <= pbyte_d;
      tmr_q   <= tmr_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      se_q    <= se_d;
    end
  end

  assign rx.data1_in    = data1_q;
  assign rx.data2_in    = data2_q;
  assign rx.data_valid  = dv_q;
  assign rx.frame_error = fe_q;
  assign rx.skew_error  = se_q;
endmodule

// File: tb/tb_laser_rx_deframer.sv
// tb_laser_rx_deframer: directed frames on both laser lanes; expected output
// pulses are derived from frame start times by the timing rules of the link.
`timescale 1ns/1ps
module tb_laser_rx_deframer;
  localparam int OS   = 8;
  localparam int SK   = 16;
  localparam int HALF = OS / 2;
  localparam int MAXC = 4096;
`ifdef LASER_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  laser_rx_deframer_if rx_if();

  laser_rx_deframer #(.OVERSAMPLE(OS), .SKEW_MAX(SK)) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .rx     (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus description
  int         fr_start [2] = '{-1, -1};
  int         fr_cut   [2] = '{-1, -1};
  logic [7:0] fr_byte  [2];
  logic       fr_stop  [2];
  bit         fr_inv = 1'b0;
  int         g_start = -1;
  int         g_len   = 0;

  // Expected output events, indexed by cycle
  bit         exp_dv [MAXC];
  bit         exp_fe [MAXC];
  bit         exp_se [MAXC];
  logic [7:0] exp_b1 [MAXC];
  logic [7:0] exp_b2 [MAXC];
  logic [7:0] mdl_d1 = 8'h00;
  logic [7:0] mdl_d2 = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int n_dv, n_fe, n_se, last_dv, last_fe, last_se;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  function automatic logic lane_level(input int l, input int c);
    int   t, idx;
    logic b;
    if (fr_start[l] < 0) return 1'b0;
    t = c - fr_start[l];
    if (t < 0 || t >= 10 * OS) return 1'b0;
    if (fr_cut[l] >= 0 && c >= fr_cut[l]) return 1'b0;
    idx = t / OS;
    if (idx == 0)      b = 1'b1;
    else if (idx <= 8) b = fr_byte[l][idx-1];
    else               b = fr_stop[l];
    if (fr_inv && (t % OS) == HALF) b = ~b;
    return b;
  endfunction

  task automatic mark_dv(input int k, input logic [7:0] b1, input logic [7:0] b2);
    if (k >= 0 && k < MAXC) begin
      exp_dv[k] = 1'b1;
      exp_b1[k] = b1;
      exp_b2[k] = b2;
    end
  endtask

  task automatic mark_fe(input int k);
    if (k >= 0 && k < MAXC) exp_fe[k] = 1'b1;
  endtask

  task automatic mark_se(input int k);
    if (k >= 0 && k < MAXC) exp_se[k] = 1'b1;
  endtask

  // Schedule one frame per lane (n<0: silent) and derive the expected outputs.
  // Line driven high at cycle n is seen synchronized at n+2; the stop bit's
  // mid-point lies 9.5 bit periods later; every reaction is registered (+1).
  task automatic plan(input int n1, input logic [7:0] b1, input logic s1,
                      input int n2, input logic [7:0] b2, input logic s2,
                      input bit inv, input int cut);
    int sa, sb, lo, hi;
    bit ga, gb;
    fr_start[0] = n1; fr_byte[0] = b1; fr_stop[0] = s1; fr_cut[0] = cut;
    fr_start[1] = n2; fr_byte[1] = b2; fr_stop[1] = s2; fr_cut[1] = cut;
    fr_inv = inv;
    if (cut >= 0) return;
    sa = n1 + 2 + 9 * OS + HALF + MAJ;
    sb = n2 + 2 + 9 * OS + HALF + MAJ;
    ga = (n1 >= 0) && !s1;
    gb = (n2 >= 0) && !s2;
    if (n1 >= 0 && s1) mark_fe(sa + 1);
    if (n2 >= 0 && s2) mark_fe(sb + 1);
    if (ga && gb) begin
      lo = (sa < sb) ? sa : sb;
      hi = (sa < sb) ? sb : sa;
      if (hi - lo <= SK) mark_dv(hi + 1, b1, b2);
      else begin
        mark_se(lo + SK + 1);
        mark_se(hi + SK + 1);
      end
    end else if (ga) mark_se(sa + SK + 1);
    else if (gb)     mark_se(sb + SK + 1);
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic clr_obs();
    n_dv = 0; n_fe = 0; n_se = 0;
    last_dv = -1; last_fe = -1; last_se = -1;
  endtask

  // Line driver
  initial begin
    rx_if.laser1_in = 1'b0;
    rx_if.laser2_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rx_if.laser1_in = lane_level(0, cyc) | (g_start >= 0 && cyc >= g_start && cyc < g_start + g_len);
      rx_if.laser2_in = lane_level(1, cyc);
    end
  end

  // Per-cycle compare against the expected event tables
  initial begin
    bit e_dv, e_fe, e_se;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_d1 = 8'h00;
        mdl_d2 = 8'h00;
        chk("rst_data_valid",  rx_if.data_valid,  1'b0);
        chk("rst_frame_error", rx_if.frame_error, 1'b0);
        chk("rst_skew_error",  rx_if.skew_error,  1'b0);
        chk("rst_data1",       rx_if.data1_in,    8'h00);
        chk("rst_data2",       rx_if.data2_in,    8'h00);
      end else begin
        e_dv = (cyc < MAXC) ? exp_dv[cyc] : 1'b0;
        e_fe = (cyc < MAXC) ? exp_fe[cyc] : 1'b0;
        e_se = (cyc < MAXC) ? exp_se[cyc] : 1'b0;
        if (e_dv) begin
          mdl_d1 = exp_b1[cyc];
          mdl_d2 = exp_b2[cyc];
        end
        chk("data_valid",  rx_if.data_valid,  e_dv);
        chk("frame_error", rx_if.frame_error, e_fe);
        chk("skew_error",  rx_if.skew_error,  e_se);
        chk("data1_in",    rx_if.data1_in,    mdl_d1);
        chk("data2_in",    rx_if.data2_in,    mdl_d2);
        if (rx_if.data_valid)  begin n_dv++; last_dv = cyc; end
        if (rx_if.frame_error) begin n_fe++; last_fe = cyc; end
        if (rx_if.skew_error)  begin n_se++; last_se = cyc; end
      end
    end
  end

  initial begin
    int n;
    clr_obs();
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(2);

    // Aligned pair 0x12 / 0x34: stop sample at n+78, data_valid at n+79
    clr_obs(); n = cyc + 3;
    plan(n, 8'h12, 1'b0, n, 8'h34, 1'b0, 1'b0, -1);
    wait_cyc(130);
    chk("t1_dv_count", n_dv, 1);
    chk("t1_dv_cycle", last_dv, n + 79 + MAJ);
    chk("t1_data1", rx_if.data1_in, 8'h12);
    chk("t1_data2", rx_if.data2_in, 8'h34);
    chk("t1_errors", n_fe + n_se, 0);

    // 2-cycle glitch on lane 1, then 0xC8 / 0x77
    clr_obs();
    g_start = cyc + 3; g_len = 2;
    wait_cyc(30);
    chk("t2_glitch_pulses", n_dv + n_fe + n_se, 0);
    n = cyc + 3;
    plan(n, 8'hC8, 1'b0, n, 8'h77, 1'b0, 1'b0, -1);
    wait_cyc(130);
    chk("t2_dv_count", n_dv, 1);
    chk("t2_data1", rx_if.data1_in, 8'hC8);
    chk("t2_data2", rx_if.data2_in, 8'h77);

    // Lane 2 bad stop bit: frame_error at n+79, lane 1 times out at n+95
    clr_obs(); n = cyc + 3;
    plan(n, 8'h99, 1'b0, n, 8'h66, 1'b1, 1'b0, -1);
    wait_cyc(130);
    chk("t3_fe_count", n_fe, 1);
    chk("t3_fe_cycle", last_fe, n + 79 + MAJ);
    chk("t3_dv_count", n_dv, 0);
    chk("t3_se_cycle", last_se, n + 95 + MAJ);
    chk("t3_data1_hold", rx_if.data1_in, 8'hC8);
    chk("t3_data2_hold", rx_if.data2_in, 8'h77);

    // Lane 2 five cycles late: data_valid at n+84
    clr_obs(); n = cyc + 3;
    plan(n, 8'hA5, 1'b0, n + 5, 8'h5A, 1'b0, 1'b0, -1);
    wait_cyc(130);
    chk("t4_dv_cycle", last_dv, n + 84 + MAJ);
    chk("t4_data1", rx_if.data1_in, 8'hA5);
    chk("t4_data2", rx_if.data2_in, 8'h5A);

    // Lane 2 silent: skew_error 16 cycles after lane-1 acceptance (n+95)
    clr_obs(); n = cyc + 3;
    plan(n, 8'h3C, 1'b0, -1, 8'h00, 1'b0, 1'b0, -1);
    wait_cyc(130);
    chk("t5_se_count", n_se, 1);
    chk("t5_se_cycle", last_se, n + 95 + MAJ);
    chk("t5_data1_hold", rx_if.data1_in, 8'hA5);

    // Skew of exactly SKEW_MAX still pairs: data_valid at n+95
    clr_obs(); n = cyc + 3;
    plan(n, 8'h11, 1'b0, n + 16, 8'h22, 1'b0, 1'b0, -1);
    wait_cyc(150);
    chk("t6_dv_cycle", last_dv, n + 95 + MAJ);
    chk("t6_se_count", n_se, 0);
    chk("t6_data2", rx_if.data2_in, 8'h22);

    // Skew of SKEW_MAX+1 fails: both bytes time out (n+95, n+112)
    clr_obs(); n = cyc + 3;
    plan(n, 8'h33, 1'b0, n + 17, 8'h44, 1'b0, 1'b0, -1);
    wait_cyc(160);
    chk("t7_dv_count", n_dv, 0);
    chk("t7_se_count", n_se, 2);
    chk("t7_se_last", last_se, n + 112 + MAJ);
    chk("t7_data1_hold", rx_if.data1_in, 8'h11);

    // Reset during lane-1 data bit 4, then aligned 0xFF / 0x00
    clr_obs(); n = cyc + 3;
    plan(n, 8'hAB, 1'b0, n, 8'hCD, 1'b0, 1'b0, n + 43);
    while (cyc < n + 43) wait_cyc(1);
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    chk("t8_data1_reset", rx_if.data1_in, 8'h00);
    chk("t8_data2_reset", rx_if.data2_in, 8'h00);
    wait_cyc(120);
    chk("t8_abort_pulses", n_dv + n_fe + n_se, 0);
    clr_obs(); n = cyc + 3;
    plan(n, 8'hFF, 1'b0, n, 8'h00, 1'b0, 1'b0, -1);
    wait_cyc(130);
    chk("t8_dv_cycle", last_dv, n + 79 + MAJ);
    chk("t8_data1", rx_if.data1_in, 8'hFF);
    chk("t8_data2", rx_if.data2_in, 8'h00);

`ifdef LASER_RX_MAJORITY_EN
    // One-cycle inversion at every mid-bit is outvoted
    clr_obs(); n = cyc + 3;
    plan(n, 8'h3C, 1'b0, n, 8'hC3, 1'b0, 1'b1, -1);
    wait_cyc(130);
    chk("t9_dv_count", n_dv, 1);
    chk("t9_data1", rx_if.data1_in, 8'h3C);
    chk("t9_data2", rx_if.data2_in, 8'hC3);
    fr_inv = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
